// File: rtl/iobus_arbiter.sv
// Two-master round-robin arbiter for the shared IOBUS: REQ/ACK handshake per master,
// fixed settle window of WAIT_CYCLES extra bus cycles per transaction.
module iobus_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ack,

    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ack,

    output logic [31:0] o_io_addr,
    output logic [31:0] o_io_wdata,
    output logic        o_io_wr,
    input  logic [31:0] i_io_rdata,
    output logic        o_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] C_WAIT    = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_win;
    logic        r_we;
    logic        r_last_gnt;
    logic [31:0] r_io_addr;
    logic [31:0] r_io_wdata;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_any_req;
    logic        w_win;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    // On a tie the master that was not granted last wins.
    always_comb begin
        w_any_req = i_m0_req | i_m1_req;
        if (i_m0_req && i_m1_req) begin
            w_win = ~r_last_gnt;
        end else begin
            w_win = i_m1_req;
        end
        w_we    = w_win ? i_m1_we    : i_m0_we;
        w_addr  = w_win ? i_m1_addr  : i_m0_addr;
        w_wdata = w_win ? i_m1_wdata : i_m0_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_last_gnt <= 1'b1;
            r_io_addr  <= 32'd0;
            r_io_wdata <= 32'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ST_ACCESS;
                        r_win      <= w_win;
                        r_last_gnt <= w_win;
                        r_we       <= w_we;
                        r_io_addr  <= w_addr;
                        r_io_wdata <= w_wdata;
                        r_cnt      <= C_WAIT;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ST_RESP;
                        // Read data is taken from the peripheral decode on the last access cycle.
                        if (!r_we) begin
                            if (r_win) begin
                                r_m1_rdata <= i_io_rdata;
                            end else begin
                                r_m0_rdata <= i_io_rdata;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_io_addr  = r_io_addr;
    assign o_io_wdata = r_io_wdata;
    assign o_io_wr    = (r_state == ST_ACCESS) && (r_cnt == 4'd0) && r_we;
    assign o_m0_ack   = (r_state == ST_RESP) && !r_win;
    assign o_m1_ack   = (r_state == ST_RESP) && r_win;
    assign o_m0_rdata = r_m0_rdata;
    assign o_m1_rdata = r_m1_rdata;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_iobus_arbiter.sv
// Bench for iobus_arbiter: instance 0 runs with no wait states, instance 1 with three;
// a transaction-timeline model is compared every cycle, plus directed literal checks.
module tb_iobus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n;
    logic [1:0]  m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack, io_wr, busy;
    logic [31:0] m0_addr [2];
    logic [31:0] m0_wdata [2];
    logic [31:0] m0_rdata [2];
    logic [31:0] m1_addr [2];
    logic [31:0] m1_wdata [2];
    logic [31:0] m1_rdata [2];
    logic [31:0] io_addr [2];
    logic [31:0] io_wdata [2];
    logic [31:0] io_rdata [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int W = gi * 3;

            iobus_arbiter #(.WAIT_CYCLES(W)) u_dut (
                .i_clk      (clk),
                .i_rst_n    (rst_n[gi]),
                .i_m0_req   (m0_req[gi]),
                .i_m0_we    (m0_we[gi]),
                .i_m0_addr  (m0_addr[gi]),
                .i_m0_wdata (m0_wdata[gi]),
                .o_m0_rdata (m0_rdata[gi]),
                .o_m0_ack   (m0_ack[gi]),
                .i_m1_req   (m1_req[gi]),
                .i_m1_we    (m1_we[gi]),
                .i_m1_addr  (m1_addr[gi]),
                .i_m1_wdata (m1_wdata[gi]),
                .o_m1_rdata (m1_rdata[gi]),
                .o_m1_ack   (m1_ack[gi]),
                .o_io_addr  (io_addr[gi]),
                .o_io_wdata (io_wdata[gi]),
                .o_io_wr    (io_wr[gi]),
                .i_io_rdata (io_rdata[gi]),
                .o_busy     (busy[gi])
            );

            // Model: t counts cycles since the grant; access is t=1..W+1, ack at t=W+2.
            logic        act, win, we, last;
            int          t;
            logic [31:0] addr, wdata, rd0, rd1;

            always @(posedge clk or negedge rst_n[gi]) begin
                if (!rst_n[gi]) begin
                    act <= 1'b0; t <= 0; win <= 1'b0; we <= 1'b0; last <= 1'b1;
                    addr <= 32'd0; wdata <= 32'd0; rd0 <= 32'd0; rd1 <= 32'd0;
                end else if (act) begin
                    if (t == W + 2) begin
                        act <= 1'b0;
                    end else begin
                        if (t == W + 1 && !we) begin
                            if (win) rd1 <= io_rdata[gi];
                            else     rd0 <= io_rdata[gi];
                        end
                        t <= t + 1;
                    end
                end else if (m0_req[gi] || m1_req[gi]) begin
                    act   <= 1'b1;
                    t     <= 1;
                    win   <= pick(m0_req[gi], m1_req[gi], last);
                    last  <= pick(m0_req[gi], m1_req[gi], last);
                    we    <= pick(m0_req[gi], m1_req[gi], last) ? m1_we[gi]    : m0_we[gi];
                    addr  <= pick(m0_req[gi], m1_req[gi], last) ? m1_addr[gi]  : m0_addr[gi];
                    wdata <= pick(m0_req[gi], m1_req[gi], last) ? m1_wdata[gi] : m0_wdata[gi];
                end
            end

            always @(posedge clk) begin
                #1;
                chk_b($sformatf("i%0d busy", gi), busy[gi], act);
                chk_b($sformatf("i%0d io_wr", gi), io_wr[gi], act && we && (t == W + 1));
                chk_b($sformatf("i%0d m0_ack", gi), m0_ack[gi], act && (t == W + 2) && !win);
                chk_b($sformatf("i%0d m1_ack", gi), m1_ack[gi], act && (t == W + 2) && win);
                chk_w($sformatf("i%0d io_addr", gi), io_addr[gi], addr);
                chk_w($sformatf("i%0d io_wdata", gi), io_wdata[gi], wdata);
                chk_w($sformatf("i%0d m0_rdata", gi), m0_rdata[gi], rd0);
                chk_w($sformatf("i%0d m1_rdata", gi), m1_rdata[gi], rd1);
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for master m's ACK on instance k; an expired bound counts as a failure.
    task automatic wait_ack(input int k, input int m, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            if ((m == 0) ? m0_ack[k] : m1_ack[k]) at = cyc;
            else tick();
        end
        if (at < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL ack timeout: inst %0d master %0d got no ack, required one within %0d cycles", k, m, bound);
        end else begin
            $display("txn: inst %0d master %0d ack at cycle %0d", k, m, at);
        end
    endtask

    initial begin
        int c0, at, nwr, wr_cyc, ack_cyc, nacc;
        logic [31:0] wr_addr, wr_data, got;
        int ids[$];
        int acs[$];
        logic drop0, drop1;

        rst_n = 2'b00;
        for (int k = 0; k < 2; k++) begin
            m0_req[k] = 0; m0_we[k] = 0; m0_addr[k] = 0; m0_wdata[k] = 0;
            m1_req[k] = 0; m1_we[k] = 0; m1_addr[k] = 0; m1_wdata[k] = 0;
            io_rdata[k] = 0;
        end

        // Reset held with both masters requesting
        m0_req[0] = 1; m0_addr[0] = 32'h1100_0000;
        m1_req[0] = 1; m1_addr[0] = 32'h1108_0000;
        io_rdata[0] = 32'h0000_A5A5;
        repeat (3) begin
            tick();
            chk_b("rst m0_ack", m0_ack[0], 1'b0);
            chk_b("rst m1_ack", m1_ack[0], 1'b0);
            chk_b("rst busy", busy[0], 1'b0);
            chk_b("rst io_wr", io_wr[0], 1'b0);
            chk_w("rst io_addr", io_addr[0], 32'h0);
            chk_w("rst m0_rdata", m0_rdata[0], 32'h0);
        end
        rst_n = 2'b11;
        c0 = cyc;

        // First tie after reset goes to M0 (a read)
        tick();
        chk_w("m0 read io_addr", io_addr[0], 32'h1100_0000);
        chk_b("m0 read io_wr", io_wr[0], 1'b0);
        wait_ack(0, 0, 10, at);
        chk_w("m0 first ack cycle", at, c0 + 2);
        chk_b("m0 first m1_ack", m1_ack[0], 1'b0);
        chk_w("m0 read rdata", m0_rdata[0], 32'h0000_A5A5);
        m0_req[0] = 0;
        io_rdata[0] = 32'h5A5A_0001;

        // M1 kept REQ high through the tie and is served next
        wait_ack(0, 1, 10, at);
        chk_w("m1 tie-loser ack cycle", at, c0 + 5);
        chk_w("m1 read rdata", m1_rdata[0], 32'h5A5A_0001);
        chk_w("m0 rdata kept", m0_rdata[0], 32'h0000_A5A5);
        m1_req[0] = 0;

        // M1 write
        tick();
        m1_we[0] = 1; m1_addr[0] = 32'h1108_0000; m1_wdata[0] = 32'h0000_1234;
        m1_req[0] = 1;
        c0 = cyc;
        nwr = 0; wr_cyc = -1; ack_cyc = -1; wr_addr = 0; wr_data = 0;
        repeat (6) begin
            tick();
            if (io_wr[0]) begin
                nwr++; wr_cyc = cyc; wr_addr = io_addr[0]; wr_data = io_wdata[0];
            end
            if (m1_ack[0]) begin
                ack_cyc = cyc;
                m1_req[0] = 0;
                $display("txn: inst 0 master 1 write ack at cycle %0d", cyc);
            end
        end
        chk_w("m1 write strobe count", nwr, 1);
        chk_w("m1 write strobe cycle", wr_cyc, c0 + 1);
        chk_w("m1 write io_addr", wr_addr, 32'h1108_0000);
        chk_w("m1 write io_wdata", wr_data, 32'h0000_1234);
        chk_w("m1 write ack cycle", ack_cyc, c0 + 2);
        chk_w("m1 write rdata kept", m1_rdata[0], 32'h5A5A_0001);

        // Contention: both masters keep re-requesting
        m1_we[0] = 0;
        m0_req[0] = 1; m1_req[0] = 1;
        drop0 = 0; drop1 = 0;
        for (int i = 0; i < 40 && ids.size() < 4; i++) begin
            tick();
            if (m0_ack[0]) begin
                ids.push_back(0); acs.push_back(cyc); m0_req[0] = 0; drop0 = 1;
                $display("txn: inst 0 contention ack master 0 at cycle %0d", cyc);
            end else if (drop0) begin
                m0_req[0] = 1; drop0 = 0;
            end
            if (m1_ack[0]) begin
                ids.push_back(1); acs.push_back(cyc); m1_req[0] = 0; drop1 = 1;
                $display("txn: inst 0 contention ack master 1 at cycle %0d", cyc);
            end else if (drop1) begin
                m1_req[0] = 1; drop1 = 0;
            end
        end
        m0_req[0] = 0; m1_req[0] = 0;
        chk_w("contention ack count", ids.size(), 4);
        for (int i = 0; i < ids.size(); i++) begin
            chk_w($sformatf("contention grant %0d", i), ids[i], i % 2);
            if (i > 0) chk_w($sformatf("contention spacing %0d", i), acs[i] - acs[i-1], 3);
        end
        repeat (2) tick();

        // Reset during the access cycle of an M1 write
        m1_we[0] = 1; m1_addr[0] = 32'h1104_0000; m1_wdata[0] = 32'h0000_DEAD;
        m1_req[0] = 1;
        tick();
        chk_b("midrst io_wr before", io_wr[0], 1'b1);
        #3;
        rst_n[0] = 1'b0;
        #1;
        chk_b("midrst io_wr drop", io_wr[0], 1'b0);
        chk_b("midrst busy drop", busy[0], 1'b0);
        m1_req[0] = 0;
        repeat (2) tick();
        rst_n[0] = 1'b1;
        repeat (6) begin
            tick();
            chk_b("midrst no m1_ack", m1_ack[0], 1'b0);
        end
        m1_we[0] = 0; io_rdata[0] = 32'h0000_0077; m1_req[0] = 1;
        c0 = cyc;
        wait_ack(0, 1, 10, at);
        chk_w("post-rst m1 ack cycle", at, c0 + 2);
        chk_w("post-rst m1 rdata", m1_rdata[0], 32'h0000_0077);
        m1_req[0] = 0;

        // WAIT_CYCLES=3 instance: single M0 read with IO_RDATA changing every cycle
        m0_addr[1] = 32'h1100_0000;
        c0 = cyc;
        io_rdata[1] = 32'hC0DE_0000 + c0;
        m0_req[1] = 1;
        at = -1; nacc = 0; got = 0;
        for (int i = 0; i < 12 && at < 0; i++) begin
            tick();
            if (m0_ack[1]) begin
                at = cyc; got = m0_rdata[1];
                $display("txn: inst 1 master 0 ack at cycle %0d", cyc);
            end else begin
                if (busy[1]) nacc++;
                io_rdata[1] = 32'hC0DE_0000 + cyc;
            end
        end
        m0_req[1] = 0;
        chk_w("w3 ack cycle", at, c0 + 5);
        chk_w("w3 access cycles", nacc, 4);
        chk_w("w3 rdata", got, 32'hC0DE_0000 + c0 + 4);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish, required finish before 100000 time units");
        $fatal(1);
    end

endmodule
